// File: rtl/dcc_pkg.sv
// Shared constants and types for the DCC PIO bank writer.
// The bank geometry matches the HPS dcc_data_0..31 / dcc_time_out PIO exports.
package dcc_pkg;

    // Words per bank (one per dcc_data PIO), word width, and timestamp width
    localparam int N_WORDS = 32;
    localparam int DATA_W  = 32;
    localparam int TIME_W  = 26;

    // Width of the overflow counter and of the fill write index
    localparam int CNT_W   = 16;
    localparam int IDX_W   = $clog2(N_WORDS);

    // Writer FSM states.
    //   FILL:   accepting words into the fill bank
    //   COMMIT: fill bank is full; copy it now if the shadow is free
    //   HOLD:   fill bank is full and the shadow is busy; wait for the HPS ack
    typedef enum logic [1:0] {
        FILL   = 2'd0,
        COMMIT = 2'd1,
        HOLD   = 2'd2
    } dcc_wr_state_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/dcc_ack_toggle.sv
// Converts the HPS read-acknowledge level into a one-cycle pulse.
// The HPS signals "done reading" by flipping hps_read_bit in either
// direction, so any change relative to the previous cycle is an ack.
// The input is already in this clock domain, so there is no synchronizer.
module dcc_ack_toggle (
    input  logic clk,
    input  logic rst_n,
    input  logic toggle,
    output logic ack
);

    logic ack_q;

    // Remember last cycle's level of the toggle input
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state is assigned with <= so every flop samples the
        // pre-edge value of its inputs, independent of block ordering.
        if (!rst_n) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= toggle;
        end
    end

    // A level change since last cycle is an acknowledge
    assign ack = toggle ^ ack_q;

endmodule

// File: rtl/dcc_bank_writer.sv
// FPGA-side producer for the HPS dcc_data PIO bank.
// Detector words fill a register bank; a full bank is copied in one cycle
// into the shadow bank that drives the PIO exports, and bank_valid is raised.
// The HPS releases the shadow by toggling hps_read_bit. Because the fill
// bank is separate from the shadow, the next bank fills while HPS reads.
module dcc_bank_writer
    import dcc_pkg::*;
(
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      in_ready,
    input  logic [TIME_W-1:0]         time_in,
    input  logic                      hps_read_bit,
    output logic [N_WORDS*DATA_W-1:0] dcc_data_flat,
    output logic [TIME_W-1:0]         dcc_time_out,
    output logic                      bank_valid,
    output logic [CNT_W-1:0]          overflow_cnt
);

    // Fill bank: packed so that word i lands at [i*DATA_W +: DATA_W] of the flat copy
    logic [N_WORDS-1:0][DATA_W-1:0] fill_bank;
    logic [TIME_W-1:0]              fill_time;
    logic [IDX_W-1:0]               wr_idx;
    dcc_wr_state_t                  state;

    logic ack;
    logic accept;
    logic do_copy;

    dcc_ack_toggle u_ack (
        .clk    (clk_clk),
        .rst_n  (reset_reset_n),
        .toggle (hps_read_bit),
        .ack    (ack)
    );

    // Ready is a pure decode of registered state, never of in_valid
    assign in_ready = (state == FILL);
    assign accept   = in_valid && in_ready;

    // Decide whether the full fill bank moves to the shadow this cycle
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        do_copy = 1'b0;
        case (state)
            COMMIT:  do_copy = !bank_valid || ack;
            HOLD:    do_copy = ack;
            default: do_copy = 1'b0;
        endcase
    end

    // Store accepted words into the fill bank
    always_ff @(posedge clk_clk) begin
        // NOTE: the fill bank is deliberately not reset. Every word is
        // rewritten before the bank can be copied, and leaving out the reset
        // keeps the 1024 storage bits off the reset tree.
        if (accept) begin
            fill_bank[wr_idx] <= in_data;
        end
    end

    // Writer FSM with the write index, bank timestamp and shadow registers
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state         <= FILL;
            wr_idx        <= '0;
            fill_time     <= '0;
            dcc_data_flat <= '0;
            dcc_time_out  <= '0;
            bank_valid    <= 1'b0;
        end else begin
            // An ack releases the shadow; the copy below overrides this when
            // both happen in the same cycle, so fresh data stays valid.
            if (ack && bank_valid) begin
                bank_valid <= 1'b0;
            end

            case (state)
                FILL: begin
                    if (accept) begin
                        if (wr_idx == '0) begin
                            fill_time <= time_in;
                        end
                        if (wr_idx == IDX_W'(N_WORDS - 1)) begin
                            wr_idx <= '0;
                            state  <= COMMIT;
                        end else begin
                            wr_idx <= wr_idx + IDX_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    state <= do_copy ? FILL : HOLD;
                end
                HOLD: begin
                    if (do_copy) begin
                        state <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase

            if (do_copy) begin
                dcc_data_flat <= fill_bank;
                dcc_time_out  <= fill_time;
                bank_valid    <= 1'b1;
            end
        end
    end

    // Count cycles where a word was offered but could not be taken
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            overflow_cnt <= '0;
        end else if (in_valid && !in_ready) begin
            overflow_cnt <= sat_inc(overflow_cnt);
        end
    end

endmodule

// File: tb/tb_dcc_bank_writer.sv
// Self-checking bench for dcc_bank_writer.
// A behavioural model tracks how many words sit in the fill bank, the shadow
// contents and the valid flag, and every cycle all outputs are compared.
module tb_dcc_bank_writer;
    import dcc_pkg::*;

    localparam int FLAT_W = N_WORDS * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [TIME_W-1:0] time_in;
    logic              hps;
    logic [FLAT_W-1:0] flat;
    logic [TIME_W-1:0] tout;
    logic              bank_valid;
    logic [CNT_W-1:0]  ovf;

    always #5 clk = ~clk;

    dcc_bank_writer dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .time_in       (time_in),
        .hps_read_bit  (hps),
        .dcc_data_flat (flat),
        .dcc_time_out  (tout),
        .bank_valid    (bank_valid),
        .overflow_cnt  (ovf)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [FLAT_W-1:0] got, input logic [FLAT_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: words held in the fill bank, shadow contents, ack history
    logic [DATA_W-1:0] m_fill   [N_WORDS];
    logic [DATA_W-1:0] m_shadow [N_WORDS];
    int                m_cnt;
    bit                m_valid;
    bit                m_prev_hps;
    logic [TIME_W-1:0] m_ftime;
    logic [TIME_W-1:0] m_stime;
    int                m_ovf;

    function automatic void model_reset();
        m_cnt      = 0;
        m_valid    = 1'b0;
        m_prev_hps = 1'b0;
        m_ftime    = '0;
        m_stime    = '0;
        m_ovf      = 0;
        for (int i = 0; i < N_WORDS; i++) m_shadow[i] = '0;
    endfunction

    // One clock of behaviour, computed from the inputs present before the edge
    function automatic void model_step();
        bit ack;
        bit ready;
        ack        = hps ^ m_prev_hps;
        ready      = (m_cnt < N_WORDS);
        m_prev_hps = hps;
        if (in_valid && !ready && m_ovf < 65535) m_ovf++;
        if (!ready && (!m_valid || ack)) begin
            for (int i = 0; i < N_WORDS; i++) m_shadow[i] = m_fill[i];
            m_stime = m_ftime;
            m_valid = 1'b1;
            m_cnt   = 0;
        end else if (ack) begin
            m_valid = 1'b0;
        end
        if (in_valid && ready) begin
            if (m_cnt == 0) m_ftime = time_in;
            m_fill[m_cnt] = in_data;
            m_cnt++;
        end
    endfunction

    function automatic logic [FLAT_W-1:0] model_flat();
        logic [FLAT_W-1:0] f;
        f = '0;
        for (int i = 0; i < N_WORDS; i++) f[i*DATA_W +: DATA_W] = m_shadow[i];
        return f;
    endfunction

    // Advance one clock, update the model, compare on the falling edge
    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        @(negedge clk);
        check("in_ready", in_ready, (m_cnt < N_WORDS));
        check("bank_valid", bank_valid, m_valid);
        check("dcc_time_out", tout, m_stime);
        check("overflow_cnt", ovf, m_ovf);
        check("dcc_data_flat", flat, model_flat());
    endtask

    // Offer n words; rnd selects random data, gaps inserts idle cycles
    task automatic feed(input int n, input logic [DATA_W-1:0] base, input bit rnd,
                        input bit gaps, input logic [TIME_W-1:0] t0);
        int k;
        bit acc;
        k = 0;
        for (int c = 0; c < 4000 && k < n; c++) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = rnd ? DATA_W'($urandom) : base + DATA_W'(k);
            time_in  = (k == 0) ? t0 : TIME_W'($urandom);
            acc      = in_valid && (m_cnt < N_WORDS);
            step();
            if (acc) k++;
        end
        in_valid = 1'b0;
        check("feed_done", k, n);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        time_in  = '0;
        hps      = 1'b0;
        model_reset();
        @(negedge clk);
        step();
        step();
        check("rst_flat", flat, '0);
        check("rst_valid", bank_valid, 1'b0);
        rst_n = 1'b1;

        // First bank: known pattern and timestamp, two-cycle latency
        feed(32, 32'h100, 1'b0, 1'b0, 26'h155);
        check("t1_valid_early", bank_valid, 1'b0);
        step();
        check("t1_valid", bank_valid, 1'b1);
        check("t1_w0", flat[0 +: DATA_W], 32'h100);
        check("t1_w31", flat[31*DATA_W +: DATA_W], 32'h11F);
        check("t1_time", tout, 26'h155);
        step();

        // Second bank with no ack: blocked in HOLD, offered words counted
        feed(32, 32'h200, 1'b0, 1'b0, 26'h0AB);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        in_valid = 1'b0;
        check("t2_ovf", ovf, 16'd5);
        check("t2_ready", in_ready, 1'b0);
        check("t2_shadow_kept", flat[0 +: DATA_W], 32'h100);
        hps = ~hps;
        step();
        check("t2_valid", bank_valid, 1'b1);
        check("t2_ready_after", in_ready, 1'b1);
        check("t2_w0", flat[0 +: DATA_W], 32'h200);
        check("t2_w31", flat[31*DATA_W +: DATA_W], 32'h21F);
        check("t2_time", tout, 26'h0AB);

        // Ack clears the shadow; a random gappy bank then copies without HOLD
        hps = ~hps;
        step();
        check("t3_cleared", bank_valid, 1'b0);
        feed(32, 32'h0, 1'b1, 1'b1, 26'h3FF_FFFF);
        step();
        check("t3_valid", bank_valid, 1'b1);
        check("t3_ready", in_ready, 1'b1);
        check("t3_time", tout, 26'h3FF_FFFF);

        // Ack arriving in the COMMIT cycle: new data copied, valid stays high
        feed(32, 32'h400, 1'b0, 1'b0, 26'h012);
        hps = ~hps;
        step();
        check("t4_valid", bank_valid, 1'b1);
        check("t4_w0", flat[0 +: DATA_W], 32'h400);
        step();
        check("t4_valid_hold", bank_valid, 1'b1);

        // Reset in the middle of a bank discards the partial words
        hps = ~hps;
        step();
        feed(17, 32'h500, 1'b0, 1'b0, 26'h077);
        rst_n = 1'b0;
        step();
        check("t5_flat", flat, '0);
        check("t5_valid", bank_valid, 1'b0);
        check("t5_time", tout, '0);
        check("t5_ovf", ovf, '0);
        rst_n = 1'b1;
        feed(32, 32'h300, 1'b0, 1'b0, 26'h2AA);
        step();
        check("t5_w0", flat[0 +: DATA_W], 32'h300);
        check("t5_w16", flat[16*DATA_W +: DATA_W], 32'h310);
        check("t5_time_after", tout, 26'h2AA);

        // hps_read_bit high through reset, then saturate the overflow count
        rst_n = 1'b0;
        hps   = 1'b1;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("t6_no_spurious", bank_valid, 1'b0);
        feed(32, 32'h600, 1'b0, 1'b0, 26'h001);
        step();
        feed(32, 32'h700, 1'b0, 1'b0, 26'h002);
        in_valid = 1'b1;
        for (int i = 0; i < 70000; i++) step();
        in_valid = 1'b0;
        check("t6_ovf_sat", ovf, 16'hFFFF);
        check("t6_w0", flat[0 +: DATA_W], 32'h600);
        check("t6_ready", in_ready, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
